perf_counter_bank: RTL and testbench

- Parametrised performance-counter bank for the single-cycle / pipelined CPU test harness; generalises the run-cycle and J/B/BS event counting of the earlier counter block.
- One run-gated cycle counter plus NUM_EVT independent event counters, each with wrap or saturate mode, sticky overflow flags, synchronous clear and freeze.
- Sits beside the CPU core; counter outputs feed the seven-segment display mux.

---
 rtl/perf_pkg.sv | 25 ++
 rtl/perf_ctr.sv | 35 +++
 rtl/perf_counter_bank.sv | 79 +++++++
 tb/tb_perf_counter_bank.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// Shared constants and the increment helper for the performance-counter bank.
package perf_pkg;

  localparam int EVT_J       = 0;
  localparam int EVT_B       = 1;
  localparam int EVT_BS      = 2;
  localparam int DEF_NUM_EVT = 3;
  localparam int DEF_CNT_W   = 16;

  // Returns {ovf, next}. The value is carried in 32 bits; width selects the all-ones point.
  function automatic logic [32:0] sat_or_wrap_inc(input logic [31:0] value,
                                                  input int unsigned width,
                                                  input logic en,
                                                  input logic saturate);
    logic [31:0] max;
    max = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    if (!en)
      return {1'b0, value};
    else if (value == max)
      return {1'b1, (saturate ? max : 32'd0)};
    else
      return {1'b0, value + 32'd1};
  endfunction

endpackage

// File: rtl/perf_ctr.sv
// Single counter with sticky overflow, synchronous clear and freeze.
module perf_ctr
  import perf_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic             freeze,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  logic [32:0] nxt;
  logic        unused_hi;

  always_comb nxt = sat_or_wrap_inc(32'(cnt), CNT_W, en, SATURATE);

  // Upper bits of the 32-bit helper result are dead when CNT_W < 32.
  assign unused_hi = ^nxt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (!freeze) begin
      cnt <= nxt[CNT_W-1:0];
      ovf <= ovf | nxt[32];
    end
  end

endmodule

// File: rtl/perf_counter_bank.sv
// Run-gated cycle counter plus NUM_EVT event counters for the CPU harness.
// Optional shadow snapshot registers when PERF_SNAPSHOT_EN is defined.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int NUM_EVT  = DEF_NUM_EVT,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int SATURATE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  input  logic [NUM_EVT-1:0]       evt,
  input  logic                     clear,
  input  logic                     freeze,
`ifdef PERF_SNAPSHOT_EN
  input  logic                     snap,
  output logic [CNT_W-1:0]         snap_cycles,
  output logic [NUM_EVT*CNT_W-1:0] snap_evt,
  output logic                     snap_valid,
`endif
  output logic [CNT_W-1:0]         cycles,
  output logic [NUM_EVT*CNT_W-1:0] evt_cnt,
  output logic [NUM_EVT:0]         ovf,
  output logic                     halt_pulse
);

  logic                          run_d;
  logic [NUM_EVT:0]              en;
  logic [NUM_EVT:0][CNT_W-1:0]   cnt;

  // Run history ignores clear/freeze so the halt pulse always fires.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_d      <= 1'b0;
      halt_pulse <= 1'b0;
    end else begin
      run_d      <= run;
      halt_pulse <= run_d & ~run;
    end
  end

  // Slot 0 is the cycle counter; the halt pulse adds the halt instruction's cycle.
  assign en = {evt, run | halt_pulse};

  for (genvar g = 0; g <= NUM_EVT; g++) begin : g_ctr
    perf_ctr #(
      .CNT_W   (CNT_W),
      .SATURATE(SATURATE != 0)
    ) u_ctr (
      .clk   (clk),
      .rst   (rst),
      .en    (en[g]),
      .clear (clear),
      .freeze(freeze),
      .cnt   (cnt[g]),
      .ovf   (ovf[g])
    );
  end

  assign cycles  = cnt[0];
  assign evt_cnt = cnt[NUM_EVT:1];

`ifdef PERF_SNAPSHOT_EN
  // Captures pre-edge values, so snap with clear keeps the counts being cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_cycles <= '0;
      snap_evt    <= '0;
      snap_valid  <= 1'b0;
    end else if (snap) begin
      snap_cycles <= cnt[0];
      snap_evt    <= cnt[NUM_EVT:1];
      snap_valid  <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_perf_counter_bank.sv
// Self-checking bench: table of per-phase vectors with a scoreboard queue, plus
// hand sequences for narrow-counter wrap/saturate and the optional snapshot.
module tb_perf_counter_bank;

  logic        clk = 1'b0;
  logic        rst, run, clear, freeze, snap;
  logic [2:0]  evt, evt_s;
  logic [15:0] cycles;
  logic [47:0] evt_cnt;
  logic [3:0]  ovf;
  logic        halt_pulse;
  logic [3:0]  cyc_w, cyc_s;
  logic [11:0] ec_w, ec_s;
  logic [3:0]  ovf_w, ovf_s;
  logic        hp_w, hp_s;
`ifdef PERF_SNAPSHOT_EN
  logic [15:0] snap_cycles;
  logic [47:0] snap_evt;
  logic        snap_valid;
  logic [3:0]  sc_w, sc_s;
  logic [11:0] se_w, se_s;
  logic        sv_w, sv_s;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  perf_counter_bank dut (
    .clk(clk), .rst(rst), .run(run), .evt(evt), .clear(clear), .freeze(freeze),
`ifdef PERF_SNAPSHOT_EN
    .snap(snap), .snap_cycles(snap_cycles), .snap_evt(snap_evt), .snap_valid(snap_valid),
`endif
    .cycles(cycles), .evt_cnt(evt_cnt), .ovf(ovf), .halt_pulse(halt_pulse));

  perf_counter_bank #(.NUM_EVT(3), .CNT_W(4), .SATURATE(0)) dut_w (
    .clk(clk), .rst(rst), .run(run), .evt(evt_s), .clear(clear), .freeze(freeze),
`ifdef PERF_SNAPSHOT_EN
    .snap(snap), .snap_cycles(sc_w), .snap_evt(se_w), .snap_valid(sv_w),
`endif
    .cycles(cyc_w), .evt_cnt(ec_w), .ovf(ovf_w), .halt_pulse(hp_w));

  perf_counter_bank #(.NUM_EVT(3), .CNT_W(4), .SATURATE(1)) dut_s (
    .clk(clk), .rst(rst), .run(run), .evt(evt_s), .clear(clear), .freeze(freeze),
`ifdef PERF_SNAPSHOT_EN
    .snap(snap), .snap_cycles(sc_s), .snap_evt(se_s), .snap_valid(sv_s),
`endif
    .cycles(cyc_s), .evt_cnt(ec_s), .ovf(ovf_s), .halt_pulse(hp_s));

  typedef struct {
    logic        rst, run;
    logic [2:0]  evt;
    logic        clear, freeze;
    int          reps;
    logic [15:0] cyc, e0, e1, e2;
    logic [3:0]  ovf;
    logic        halt;
  } vec_t;

  vec_t tbl[20];
  vec_t exp_q[$];

  task automatic chk(input string nm, input int row, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (row %0d): got %0d expected %0d", nm, row, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t e;
    rst = 1'b1; run = 1'b0; evt = '0; evt_s = '0; clear = 1'b0; freeze = 1'b0; snap = 1'b0;

    //           rst run evt    clr frz reps cyc e0 e1 e2 ovf halt
    tbl[0]  = '{1, 0, 3'b000, 0, 0, 2,  0,  0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 3'b000, 0, 0, 10, 10, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 3'b000, 0, 0, 1,  10, 0, 0, 0, 0, 1};
    tbl[3]  = '{0, 0, 3'b000, 0, 0, 1,  11, 0, 0, 0, 0, 0};
    tbl[4]  = '{0, 0, 3'b000, 0, 0, 3,  11, 0, 0, 0, 0, 0};
    tbl[5]  = '{0, 1, 3'b000, 0, 0, 1,  12, 0, 0, 0, 0, 0};
    tbl[6]  = '{0, 0, 3'b000, 0, 0, 1,  12, 0, 0, 0, 0, 1};
    tbl[7]  = '{0, 1, 3'b000, 0, 0, 1,  13, 0, 0, 0, 0, 0};  // run back during pulse: +1 only
    tbl[8]  = '{0, 0, 3'b000, 0, 0, 1,  13, 0, 0, 0, 0, 1};
    tbl[9]  = '{0, 0, 3'b000, 0, 0, 1,  14, 0, 0, 0, 0, 0};
    tbl[10] = '{0, 0, 3'b000, 1, 0, 1,  0,  0, 0, 0, 0, 0};
    tbl[11] = '{0, 0, 3'b111, 0, 0, 5,  0,  5, 5, 5, 0, 0};
    tbl[12] = '{0, 0, 3'b010, 0, 0, 3,  0,  5, 8, 5, 0, 0};
    tbl[13] = '{0, 1, 3'b001, 0, 1, 4,  0,  5, 8, 5, 0, 0};
    tbl[14] = '{0, 0, 3'b000, 1, 1, 1,  0,  0, 0, 0, 0, 1};  // clear beats freeze, pulse survives
    tbl[15] = '{0, 0, 3'b000, 0, 0, 1,  1,  0, 0, 0, 0, 0};
    tbl[16] = '{0, 0, 3'b000, 1, 0, 1,  0,  0, 0, 0, 0, 0};
    tbl[17] = '{0, 1, 3'b100, 0, 0, 7,  7,  0, 0, 7, 0, 0};
    tbl[18] = '{1, 1, 3'b100, 0, 0, 1,  0,  0, 0, 0, 0, 0};
    tbl[19] = '{0, 1, 3'b100, 0, 0, 3,  3,  0, 0, 3, 0, 0};

    for (int r = 0; r < 20; r++) begin
      rst = tbl[r].rst; run = tbl[r].run; evt = tbl[r].evt;
      clear = tbl[r].clear; freeze = tbl[r].freeze;
      for (int k = 0; k < tbl[r].reps; k++) begin
        if (k == tbl[r].reps - 1) exp_q.push_back(tbl[r]);
        tick();
        if (k == tbl[r].reps - 1) begin
          e = exp_q.pop_front();
          chk("cycles", r, cycles, e.cyc);
          chk("evt_ch0", r, evt_cnt[15:0], e.e0);
          chk("evt_ch1", r, evt_cnt[31:16], e.e1);
          chk("evt_ch2", r, evt_cnt[47:32], e.e2);
          chk("ovf", r, ovf, e.ovf);
          chk("halt_pulse", r, halt_pulse, e.halt);
        end
      end
    end

    // Narrow counters: wrap vs saturate on channel 0.
    run = 1'b0; evt = '0; clear = 1'b0; freeze = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    evt_s = 3'b001;
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (k == 15) begin
        chk("wrap_ch0_at15", k, ec_w[3:0], 15); chk("wrap_ovf_at15", k, ovf_w[1], 0);
        chk("sat_ch0_at15", k, ec_s[3:0], 15);  chk("sat_ovf_at15", k, ovf_s[1], 0);
      end
      if (k == 16) begin
        chk("wrap_ch0_at16", k, ec_w[3:0], 0);  chk("wrap_ovf_at16", k, ovf_w[1], 1);
        chk("sat_ch0_at16", k, ec_s[3:0], 15);  chk("sat_ovf_at16", k, ovf_s[1], 1);
      end
    end
    chk("wrap_ch0_17", 17, ec_w[3:0], 1);  chk("wrap_ovf_17", 17, ovf_w[1], 1);
    chk("sat_ch0_17", 17, ec_s[3:0], 15);  chk("sat_ovf_17", 17, ovf_s[1], 1);
    chk("wrap_ch1_idle", 17, ec_w[7:4], 0);
    evt_s = '0;

`ifdef PERF_SNAPSHOT_EN
    clear = 1'b1; tick(); clear = 1'b0;
    chk("snap_valid_reset", 0, snap_valid, 0);
    run = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    chk("snap_pre_cycles", 0, cycles, 20);
    snap = 1'b1; clear = 1'b1; tick(); snap = 1'b0; clear = 1'b0; run = 1'b0;
    chk("snap_cycles", 0, snap_cycles, 20);
    chk("snap_valid", 0, snap_valid, 1);
    chk("snap_cleared_cycles", 0, cycles, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
